// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store controller between the memory-stage request port and a word RAM,
// with load extension, read-modify-write sub-word stores and misalignment rejection.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [31:0]           req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_err_o,
  output logic [ADDR_WIDTH-1:0] mem_A_o,
  output logic [31:0]           mem_WD_o,
  output logic                  mem_we_o,
  input  logic [31:0]           mem_RD_i
);
  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [31:0]           rdata_q, wd_q;
  logic                  err_q, valid_q, we_q;
  logic [1:0]            lane;
  logic [2:0]            f3;
  logic                  size_ok, code_ok, legal;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           load_val, store_val;
  logic                  unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[31:ADDR_WIDTH+2];
  always_comb begin
    lane      = req_addr_i[1:0];
    f3        = req_funct3_i;
    size_ok   = f3[1:0] == 2'b00 ? 1'b1 : f3[1:0] == 2'b01 ? ~lane[0] : f3[1:0] == 2'b10 ? lane == 2'b00 : 1'b0;
    code_ok   = req_we_i ? ~f3[2] & (f3[1:0] != 2'b11) : (f3[1:0] != 2'b11) & ~(f3[2] & f3[1]);
    legal     = size_ok & code_ok;
    byte_sel  = mem_RD_i[{lane, 3'b000} +: 8];
    half_sel  = mem_RD_i[{lane[1], 4'b0000} +: 16];
    load_val  = f3[1:0] == 2'b00 ? {{24{~f3[2] & byte_sel[7]}}, byte_sel} :
                f3[1:0] == 2'b01 ? {{16{~f3[2] & half_sel[15]}}, half_sel} : mem_RD_i;
    store_val = mem_RD_i;
    if (f3[1:0] == 2'b00)
      store_val[{lane, 3'b000} +: 8] = req_wdata_i[7:0];
    else if (f3[1:0] == 2'b01)
      store_val[{lane[1], 4'b0000} +: 16] = req_wdata_i[15:0];
    else
      store_val = req_wdata_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      waddr_q <= '0;
      rdata_q <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          waddr_q <= req_addr_i[ADDR_WIDTH+1:2];
          if (!legal) begin
            state_q <= RESP;
            valid_q <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (req_we_i) begin
            state_q <= WRITE;
            we_q    <= 1'b1;
            wd_q    <= store_val;
          end else begin
            state_q <= RESP;
            valid_q <= 1'b1;
            rdata_q <= load_val;
          end
        end
        WRITE: begin
          state_q <= RESP;
          we_q    <= 1'b0;
          valid_q <= 1'b1;
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        RESP: if (resp_ready_i) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // The RAM address follows the request port while idle so mem_RD is ready at the accept edge.
  assign mem_A_o      = state_q == WRITE ? waddr_q : req_addr_i[ADDR_WIDTH+1:2];
  assign mem_WD_o     = wd_q;
  assign mem_we_o     = we_q;
  assign req_ready_o  = state_q == IDLE;
  assign resp_valid_o = valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed and randomized load/store traffic against a byte-lane
// reference model of the RAM, with cycle-exact handshake checks.
module tb_data_mem_ctrl;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata, mem_WD, mem_RD;
  logic [9:0]  mem_A;
  logic        mem_we;
  logic [31:0] ram [1024];
  logic [31:0] ref_mem [1024];
  int          n_err = 0, n_chk = 0, we_pulses = 0, exp_pulses = 0;
  logic [31:0] rd, wd;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_A_o(mem_A), .mem_WD_o(mem_WD), .mem_we_o(mem_we), .mem_RD_i(mem_RD)
  );

  assign mem_RD = ram[mem_A];
  always @(posedge clk) if (mem_we) begin
    ram[mem_A] <= mem_WD;
    we_pulses  <= we_pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the controller idle; returns at the negedge after the response handshake.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input int stall,
                      output logic [31:0] obs_rd, output logic [31:0] obs_wd);
    int          wi = int'(addr[11:2]);
    int          size, sh;
    logic        legal;
    logic [31:0] w, val, mask, nw, exp_rd;
    w     = ref_mem[wi];
    sh    = 8 * int'(addr[1:0]);
    size  = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    legal = (we ? f3 inside {3'd0, 3'd1, 3'd2} : f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
            && (addr % size == 0);
    val = w >> sh;
    if (size == 1) val = (f3[2] || !val[7]) ? (val & 32'hFF) : (val | 32'hFFFF_FF00);
    if (size == 2) val = (f3[2] || !val[15]) ? (val & 32'hFFFF) : (val | 32'hFFFF_0000);
    mask   = size == 4 ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1) << sh;
    nw     = (w & ~mask) | ((wdata << sh) & mask);
    exp_rd = (legal && !we) ? val : 32'd0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    obs_wd = 32'd0;
    if (legal && we) begin
      chk("write_we", {31'd0, mem_we}, 32'd1);
      chk("write_A", {22'd0, mem_A}, 32'(wi));
      chk("write_WD", mem_WD, nw);
      chk("write_no_resp", {31'd0, resp_valid}, 32'd0);
      obs_wd = mem_WD;
      exp_pulses++;
      @(negedge clk);
    end
    chk("we_low", {31'd0, mem_we}, 32'd0);
    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_err", {31'd0, resp_err}, {31'd0, !legal});
    chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
    obs_rd = resp_rdata;
    repeat (stall) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, resp_valid}, 32'd1);
      chk("stall_rdata", resp_rdata, exp_rd);
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_valid", {31'd0, resp_valid}, 32'd0);
    chk("post_ready", {31'd0, req_ready}, 32'd1);
    if (legal && we) ref_mem[wi] = nw;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_WD", mem_WD, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    xact(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, rd, wd);
    chk("sw_wd", wd, 32'hDEAD_BEEF);
    xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, wd);
    chk("lw_rd", rd, 32'hDEAD_BEEF);
    xact(1'b1, 3'd2, 32'h20, 32'h1122_3344, 0, rd, wd);
    xact(1'b1, 3'd0, 32'h22, 32'h5555_55AB, 0, rd, wd);
    chk("sb_wd", wd, 32'h11AB_3344);
    xact(1'b1, 3'd1, 32'h20, 32'h9999_CDEF, 0, rd, wd);
    chk("sh_wd", wd, 32'h11AB_CDEF);
    xact(1'b1, 3'd2, 32'h30, 32'h80F0_7F01, 0, rd, wd);
    xact(1'b0, 3'd0, 32'h33, 32'h0, 0, rd, wd);
    chk("lb", rd, 32'hFFFF_FF80);
    xact(1'b0, 3'd4, 32'h33, 32'h0, 0, rd, wd);
    chk("lbu", rd, 32'h0000_0080);
    xact(1'b0, 3'd1, 32'h32, 32'h0, 0, rd, wd);
    chk("lh", rd, 32'hFFFF_80F0);
    xact(1'b0, 3'd5, 32'h30, 32'h0, 0, rd, wd);
    chk("lhu", rd, 32'h0000_7F01);
    xact(1'b0, 3'd2, 32'h31, 32'h0, 0, rd, wd);
    chk("err_lw_rd", rd, 32'd0);
    xact(1'b1, 3'd1, 32'h21, 32'hFFFF_FFFF, 0, rd, wd);
    xact(1'b1, 3'd3, 32'h20, 32'hFFFF_FFFF, 0, rd, wd);
    xact(1'b0, 3'd3, 32'h20, 32'h0, 0, rd, wd);
    xact(1'b0, 3'd2, 32'h20, 32'h0, 0, rd, wd);
    chk("err_mem_kept", rd, 32'h11AB_CDEF);
    xact(1'b0, 3'd2, 32'h10, 32'h0, 5, rd, wd);
    chk("bp_rd", rd, 32'hDEAD_BEEF);
    // Reset asserted in the WRITE cycle must cancel the store.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rw_we_before", {31'd0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rw_we", {31'd0, mem_we}, 32'd0);
    chk("rw_ready", {31'd0, req_ready}, 32'd1);
    chk("rw_valid", {31'd0, resp_valid}, 32'd0);
    chk("rw_rdata", resp_rdata, 32'd0);
    chk("rw_err", {31'd0, resp_err}, 32'd0);
    chk("rw_WD", mem_WD, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xact(1'b0, 3'd2, 32'h40, 32'h0, 0, rd, wd);
    chk("rw_mem_kept", rd, ref_mem[16]);
    for (int i = 0; i < 80; i++) begin
      logic [31:0] r, a;
      logic [3:0]  idx;
      logic [1:0]  off;
      r   = $urandom;
      idx = 4'($urandom_range(0, 15));
      off = 2'($urandom_range(0, 3));
      a   = {r[31:12], 6'd0, idx, off};
      xact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
           $urandom_range(0, 2), rd, wd);
    end
    chk("we_pulse_count", 32'(we_pulses), 32'(exp_pulses));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
